// File: rtl/layer_ctrl.sv
// Frame-synchronous layer visibility controller: stores per-layer visibility commands
// and, once per frame, sweeps all layers to produce a tear-free enable mask for the mux.
module layer_ctrl #(
  parameter int                  N_LAYERS   = 14,
  parameter int                  BLINK_HALF = 8,
  parameter logic [N_LAYERS-1:0] RESET_MASK = 14'h3FFF
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_layer,
  input  logic [1:0]          cfg_op,
  input  logic [7:0]          cfg_arg,
  output logic [N_LAYERS-1:0] layer_en,
  output logic                frame_done,
  output logic                cfg_err,
  output logic                overrun
);

  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_COMMIT} state_t;
  typedef enum logic [2:0] {M_OFF, M_ON, M_BLINK, M_BLINK_FOREVER, M_TIMED} mode_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     sweep_idx_reg;
  logic [7:0]           blink_cnt_reg;
  logic                 blink_phase_reg;
  logic [N_LAYERS-1:0]  next_en_reg;
  logic [N_LAYERS-1:0]  layer_en_reg;
  logic                 ready_reg;
  logic                 frame_done_reg;
  logic                 cfg_err_reg;
  logic                 overrun_reg;
  mode_t                mode_reg [N_LAYERS];
  logic [7:0]           rem_reg  [N_LAYERS];

  logic                 accept;
  logic                 in_range;
  logic                 cmd_hit;
  mode_t                cmd_mode;
  logic [7:0]           cmd_rem;
  mode_t                cur_mode, sw_mode;
  logic [7:0]           cur_rem, sw_rem;
  logic                 sw_en;

  // cfg_ready is only ever high while the FSM sits in IDLE, so it doubles as the accept gate.
  assign accept   = cfg_valid & ready_reg;
  assign in_range = (32'(cfg_layer) < N_LAYERS);
  assign cmd_hit  = accept & in_range;

  always_comb begin
    cmd_mode = M_OFF;
    cmd_rem  = 8'd0;
    case (cfg_op)
      2'd0: cmd_mode = M_OFF;
      2'd1: cmd_mode = M_ON;
      2'd2: begin
        if (cfg_arg == 8'd0) begin
          cmd_mode = M_BLINK_FOREVER;
        end else begin
          cmd_mode = M_BLINK;
          cmd_rem  = cfg_arg;
        end
      end
      default: begin
        cmd_mode = M_TIMED;
        cmd_rem  = cfg_arg;
      end
    endcase
  end

  // Per-layer update for the layer currently under the sweep pointer.
  always_comb begin
    cur_mode = mode_reg[sweep_idx_reg];
    cur_rem  = rem_reg[sweep_idx_reg];
    sw_mode  = cur_mode;
    sw_rem   = cur_rem;
    sw_en    = 1'b0;
    case (cur_mode)
      M_OFF:           sw_en = 1'b0;
      M_ON:            sw_en = 1'b1;
      M_BLINK_FOREVER: sw_en = blink_phase_reg;
      M_BLINK, M_TIMED: begin
        if (cur_rem == 8'd0) begin
          sw_mode = M_OFF;
          sw_en   = 1'b0;
        end else begin
          sw_rem = cur_rem - 8'd1;
          sw_en  = (cur_mode == M_TIMED) ? 1'b1 : blink_phase_reg;
        end
      end
      default: begin
        sw_mode = M_OFF;
        sw_en   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (startOfFrame) state_next = S_SWEEP;
      S_SWEEP:  if (sweep_idx_reg == IDX_W'(N_LAYERS - 1)) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_reg       <= S_IDLE;
      sweep_idx_reg   <= '0;
      blink_cnt_reg   <= 8'd0;
      blink_phase_reg <= 1'b1;
      next_en_reg     <= '0;
      layer_en_reg    <= RESET_MASK;
      ready_reg       <= 1'b0;
      frame_done_reg  <= 1'b0;
      cfg_err_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      for (int i = 0; i < N_LAYERS; i++) begin
        mode_reg[i] <= RESET_MASK[i] ? M_ON : M_OFF;
        rem_reg[i]  <= 8'd0;
      end
    end else begin
      state_reg      <= state_next;
      ready_reg      <= (state_next == S_IDLE);
      frame_done_reg <= 1'b0;
      cfg_err_reg    <= accept & ~in_range;
      overrun_reg    <= startOfFrame & (state_reg != S_IDLE);

      // Commands are only accepted in IDLE, so they never collide with sweep writes.
      for (int i = 0; i < N_LAYERS; i++) begin
        if (cmd_hit && cfg_layer == 4'(i)) begin
          mode_reg[i] <= cmd_mode;
          rem_reg[i]  <= cmd_rem;
        end else if (state_reg == S_SWEEP && sweep_idx_reg == IDX_W'(i)) begin
          mode_reg[i] <= sw_mode;
          rem_reg[i]  <= sw_rem;
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (startOfFrame) begin
            sweep_idx_reg <= '0;
            if (blink_cnt_reg == 8'(BLINK_HALF - 1)) begin
              blink_cnt_reg   <= 8'd0;
              blink_phase_reg <= ~blink_phase_reg;
            end else begin
              blink_cnt_reg <= blink_cnt_reg + 8'd1;
            end
          end
        end
        S_SWEEP: begin
          next_en_reg[sweep_idx_reg] <= sw_en;
          sweep_idx_reg              <= sweep_idx_reg + IDX_W'(1);
        end
        S_COMMIT: begin
          layer_en_reg   <= next_en_reg;
          frame_done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready  = ready_reg;
  assign layer_en   = layer_en_reg;
  assign frame_done = frame_done_reg;
  assign cfg_err    = cfg_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: doc/layer_ctrl.md
# layer_ctrl

Frame-synchronous layer-visibility controller for the VGA `objects_mux`. Game logic issues per-layer visibility commands through a valid/ready port: off, on, blink, or timed-on. The block stores them per layer and, at each start of frame, sweeps all layers one per cycle to advance timers and blink state. It then commits a tear-free enable mask (`layer_en`). That mask gates each layer's drawing request (`xxxDR & layer_en[i]`) before the mux priority chain.

## Interface
- `N_LAYERS`, 14: number of gated layers (index 0 = highest mux priority).
- `BLINK_HALF`, 8: frames per blink half-period (1..255).
- `RESET_MASK`, 14'h3FFF: `layer_en` value at and after reset.
- `clk` in 1: pixel clock.
- `resetN` in 1: reset, synchronous, active-high (1 = reset), one clock.
- `startOfFrame` in 1: one-cycle pulse at frame start.
- `cfg_valid` in 1: command valid.
- `cfg_ready` out 1: command accepted when `cfg_valid & cfg_ready`.
- `cfg_layer` in 4: target layer index.
- `cfg_op` in 2: 0 OFF, 1 ON, 2 BLINK, 3 TIMED_ON.
- `cfg_arg` in 8: frame count for BLINK/TIMED_ON (BLINK 0 = forever).
- `layer_en` out N_LAYERS: committed visibility mask.
- `frame_done` out 1: one-cycle pulse on the commit cycle.
- `cfg_err` out 1: one-cycle pulse when an accepted command is dropped.
- `overrun` out 1: one-cycle pulse when `startOfFrame` arrives while not IDLE.

## Operation
- **Per-layer state:** `mode` is OFF, ON, BLINK, BLINK_FOREVER or TIMED. Each layer also has an 8-bit `remaining` counter and a working bit `next_en[i]`.
- **Reset:** all layers are ON if their `RESET_MASK` bit is set, else OFF; `remaining` = 0.
- **Reset outputs:** `layer_en` = RESET_MASK, `cfg_ready` = 0, and `frame_done`, `cfg_err`, `overrun` = 0.
- **Reset internals:** `blink_cnt` = 0, `blink_phase` = 1, FSM = IDLE.
- **FSM states:** IDLE, SWEEP, COMMIT.
- **IDLE:**
  - `cfg_ready` = 1.
  - An accept writes the addressed layer's `mode` and `remaining` immediately: OFF/ON clear `remaining`; BLINK with arg 0 becomes BLINK_FOREVER; otherwise `remaining` = arg.
  - When several commands hit the same layer in one frame, the last accepted wins.
  - `cfg_layer` ≥ N_LAYERS is accepted, the state is unchanged, and `cfg_err` pulses the next cycle.
  - On `startOfFrame`: `sweep_idx` ← 0 and the FSM goes to SWEEP.
  - Also on `startOfFrame`, `blink_cnt` advances. When it reaches BLINK_HALF-1, it wraps to 0 and `blink_phase` toggles.
  - If `startOfFrame` and an accept occur in the same cycle, the command is applied before the sweep and takes effect this frame.
- **SWEEP:**
  - `cfg_ready` = 0. One layer is processed per cycle at index `sweep_idx`.
  - OFF → `next_en` = 0.
  - ON → `next_en` = 1.
  - BLINK_FOREVER → `next_en` = `blink_phase`.
  - TIMED or BLINK with `remaining` = 0 → mode becomes OFF, `next_en` = 0.
  - TIMED or BLINK with `remaining` ≠ 0 → `remaining` −1; `next_en` = 1 (TIMED) or `blink_phase` (BLINK).
  - After index N_LAYERS-1 the FSM goes to COMMIT.
- **COMMIT:** `layer_en` ← `next_en`, `frame_done` = 1, then return to IDLE.
- **Resulting counts:** TIMED_ON with arg n is visible for exactly n committed frames, and arg 0 gives off at the next commit. BLINK with arg n runs n frames, then goes off.
- **Overrun:** `startOfFrame` in SWEEP/COMMIT is ignored and `overrun` pulses. The sweep continues, and `blink_cnt` does not advance.
- **Reset mid-sweep:** reset dominates. Outputs return to reset values the next cycle, and no partial commit occurs.

## Timing
- `startOfFrame` at cycle t: SWEEP runs cycles t+1..t+N_LAYERS. COMMIT is at t+N_LAYERS+1, with `layer_en`/`frame_done` visible at t+N_LAYERS+2 (16 cycles after the pulse for N=14).
- `layer_en` changes only at COMMIT and is otherwise stable for the whole frame.
- `cfg_ready` falls the cycle after `startOfFrame` and rises the cycle after COMMIT. A held `cfg_valid` stays pending with no loss.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `resetN`=1 for 3 cycles → `layer_en`=14'h3FFF, `cfg_ready`=0. Release → `cfg_ready`=1 the next cycle.
- **Commit latency:** OFF to layer 5, then `startOfFrame` at t → `layer_en[5]`=1 until t+15, 0 from t+16, with `frame_done` pulsing at t+16. A command accepted mid-frame leaves `layer_en` unchanged.
- **TIMED_ON:** layer 0 (game over) arg 3 after an OFF; run 5 frames → `layer_en[0]` per frame 1,1,1,0,0.
- **BLINK:** BLINK_HALF=2, BLINK_FOREVER on layer 6 from reset (`blink_cnt`=0, `blink_phase`=1) → `layer_en[6]` over frames 1..8 = 1,0,0,1,1,0,0,1. BLINK arg 4 starting at that phase → 1,0,0,1, then 0.
- **Stall and conflicts:** assert `cfg_valid` during SWEEP → no accept until IDLE, and the command is applied once. ON then OFF to layer 2 in one frame → `layer_en[2]`=0. `cfg_layer`=15 → `cfg_err` pulses and the mask is unchanged.
- **Overrun and reset:** a second `startOfFrame` 5 cycles after the first → `overrun` pulses once and the commit is still at +16. Reset at sweep cycle 7 → `layer_en`=RESET_MASK, FSM IDLE, no `frame_done`.
